// File: rtl/exc_status_queue.sv
// rtl/exc_status_queue.sv - rstatus exception classifier with FIFO buffering toward writeback
// Classifies ALU/multdiv exceptions into 3-bit codes, queues them, and hands them out by valid/ready.
module exc_status_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [4:0]            ex_opcode,
  input  logic [4:0]            ex_aluop,
  input  logic                  ex_ovf,
  input  logic                  md_done,
  input  logic                  md_is_div,
  input  logic                  md_exc,
  input  logic                  st_ready,
  input  logic                  clr,
  output logic                  st_valid,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic                  stall,
  output logic [CNT_WIDTH-1:0]  exc_count,
  output logic                  drop_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int OW  = AW + 1;
  localparam int CW1 = CNT_WIDTH + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  logic [2:0]           mem_q [DEPTH];
  logic [2:0]           mem_d [DEPTH];
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]        occ_q, occ_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 drop_q, drop_d;

  logic                 alu_hit, md_hit;
  logic [2:0]           alu_code, md_code;
  logic                 p0_v, p1_v;
  logic [2:0]           p0_code, p1_code;
  logic                 pop;
  logic [OW-1:0]        cap;
  logic                 acc0, acc1, dropped;
  logic [1:0]           n_acc;
  logic [CW1-1:0]       cnt_sum;

  always_comb begin
    alu_code = 3'd0;
    if (ex_opcode == 5'b00101)
      alu_code = 3'd2;
    else if (ex_opcode == 5'b00000 && ex_aluop == 5'b00000)
      alu_code = 3'd1;
    else if (ex_opcode == 5'b00000 && ex_aluop == 5'b00001)
      alu_code = 3'd3;
    alu_hit = ex_valid & ex_ovf & (alu_code != 3'd0);
    md_hit  = md_done & md_exc;
    md_code = md_is_div ? 3'd5 : 3'd4;
  end

  // Multdiv result belongs to the older instruction, so it takes the first slot.
  always_comb begin
    p0_v    = md_hit | alu_hit;
    p0_code = md_hit ? md_code : alu_code;
    p1_v    = md_hit & alu_hit;
    p1_code = alu_code;
  end

  always_comb begin
    pop     = st_valid & st_ready;
    cap     = DEPTH_C - occ_q + OW'(pop);
    acc0    = p0_v & (cap >= OW'(1));
    acc1    = p1_v & (cap >= OW'(2));
    n_acc   = 2'(acc0) + 2'(acc1);
    dropped = (p0_v & ~acc0) | (p1_v & ~acc1);
  end

  always_comb begin
    mem_d = mem_q;
    if (acc0)
      mem_d[wr_ptr_q] = p0_code;
    if (acc1)
      mem_d[wr_ptr_q + AW'(1)] = p1_code;
    wr_ptr_d = wr_ptr_q + AW'(n_acc);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + OW'(n_acc) - OW'(pop);

    cnt_sum  = {1'b0, cnt_q} + CW1'(n_acc);
    cnt_d    = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
    drop_d   = drop_q | dropped;
    // Clear wins over anything counted or dropped in the same cycle.
    if (clr) begin
      cnt_d  = '0;
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= 3'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    st_valid  = (occ_q != '0);
    st_data   = st_valid ? {{(DATA_WIDTH-3){1'b0}}, mem_q[rd_ptr_q]} : '0;
    stall     = (DEPTH_C - occ_q) < OW'(2);
    exc_count = cnt_q;
    drop_err  = drop_q;
  end

endmodule

// File: tb/tb_exc_status_queue.sv
// tb/tb_exc_status_queue.sv - self-checking bench for exc_status_queue
// Directed vector table, then model-checked saturation and random phases.
module tb_exc_status_queue;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ex_valid = 1'b0, ex_ovf = 1'b0;
  logic [4:0]    ex_opcode = '0, ex_aluop = '0;
  logic          md_done = 1'b0, md_is_div = 1'b0, md_exc = 1'b0;
  logic          st_ready = 1'b0, clr = 1'b0;
  logic          st_valid, stall, drop_err;
  logic [DW-1:0] st_data;
  logic [CW-1:0] exc_count;

  int checks = 0;
  int errors = 0;

  exc_status_queue #(.DATA_WIDTH(DW), .DEPTH(DP), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_aluop(ex_aluop), .ex_ovf(ex_ovf), .md_done(md_done), .md_is_div(md_is_div),
    .md_exc(md_exc), .st_ready(st_ready), .clr(clr), .st_valid(st_valid),
    .st_data(st_data), .stall(stall), .exc_count(exc_count), .drop_err(drop_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, ev;
    logic [4:0] op, al;
    logic       ovf, mdd, mdiv, mexc, rdy, clr;
    logic       e_v;
    logic [2:0] e_d;
    logic       e_s;
    int         e_c;
    logic       e_dr;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: plain queue of codes, integer counter, sticky bit.
  int mq[$];
  int mcnt;
  bit mdrop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic ev, input logic [4:0] op,
                              input logic [4:0] al, input logic ovf, input logic mdd,
                              input logic mdiv, input logic mexc, input logic rdy,
                              input logic c, input logic v, input logic [2:0] d,
                              input logic s, input int cnt, input logic dr);
    vec_t r;
    r.rst = rst; r.ev = ev; r.op = op; r.al = al; r.ovf = ovf;
    r.mdd = mdd; r.mdiv = mdiv; r.mexc = mexc; r.rdy = rdy; r.clr = c;
    r.e_v = v; r.e_d = d; r.e_s = s; r.e_c = cnt; r.e_dr = dr;
    return r;
  endfunction

  task automatic drive(input logic rst, input logic ev, input logic [4:0] op,
                       input logic [4:0] al, input logic ovf, input logic mdd,
                       input logic mdiv, input logic mexc, input logic rdy, input logic c);
    reset = rst; ex_valid = ev; ex_opcode = op; ex_aluop = al; ex_ovf = ovf;
    md_done = mdd; md_is_div = mdiv; md_exc = mexc; st_ready = rdy; clr = c;
  endtask

  function automatic int alu_class(input logic [4:0] op, input logic [4:0] al);
    if (op == 5'd5) return 2;
    if (op == 5'd0 && al == 5'd0) return 1;
    if (op == 5'd0 && al == 5'd1) return 3;
    return 0;
  endfunction

  task automatic mstep(input string tag, input logic rst, input logic ev, input logic [4:0] op,
                       input logic [4:0] al, input logic ovf, input logic mdd,
                       input logic mdiv, input logic mexc, input logic rdy, input logic c);
    int pushes[$];
    int free, nacc, ac;
    bit dropped;
    drive(rst, ev, op, al, ovf, mdd, mdiv, mexc, rdy, c);
    nacc = 0;
    dropped = 0;
    if (rst) begin
      mq.delete();
      mcnt = 0;
      mdrop = 0;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      free = DP - mq.size();
      if (mdd && mexc) pushes.push_back(mdiv ? 5 : 4);
      ac = alu_class(op, al);
      if (ev && ovf && ac != 0) pushes.push_back(ac);
      foreach (pushes[i]) begin
        if (free > 0) begin
          mq.push_back(pushes[i]);
          free--;
          nacc++;
        end else begin
          dropped = 1;
        end
      end
      if (c) begin
        mcnt = 0;
        mdrop = 0;
      end else begin
        mcnt = (mcnt + nacc > (1 << CW) - 1) ? (1 << CW) - 1 : mcnt + nacc;
        mdrop = mdrop | dropped;
      end
    end
    @(posedge clock);
    #1;
    chk({tag, "_valid"}, 32'(st_valid), 32'(mq.size() > 0));
    chk({tag, "_data"}, st_data, (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'((DP - mq.size()) < 2));
    chk({tag, "_count"}, 32'(exc_count), 32'(mcnt));
    chk({tag, "_drop"}, 32'(drop_err), 32'(mdrop));
  endtask

  initial begin
    //                rst ev op al ovf mdd div exc rdy clr   v d s c dr
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 0, 0,  0, 0,   1, 1, 0, 1, 0)); // add
    vecs.push_back(mk(0, 1, 5, 0, 1,  0, 0, 0,  0, 0,   1, 1, 0, 2, 0)); // addi
    vecs.push_back(mk(0, 1, 0, 1, 1,  0, 0, 0,  0, 0,   1, 1, 1, 3, 0)); // sub
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0,   1, 2, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0,   1, 3, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0,   0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 0)); // clr
    vecs.push_back(mk(0, 1, 7, 0, 1,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0)); // opcode 7
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0)); // no ovf
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0)); // not valid
    vecs.push_back(mk(0, 1, 0, 2, 1,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0)); // aluop 2
    vecs.push_back(mk(0, 1, 0, 1, 1,  1, 1, 1,  0, 0,   1, 5, 0, 2, 0)); // div + sub
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0,   1, 3, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0,   0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0,  0, 0,   0, 0, 0, 2, 0)); // md no exc
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 1,   0, 0, 0, 0, 0)); // clr
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 0, 0,  0, 0,   1, 1, 0, 1, 0)); // add
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 1,  0, 0,   1, 1, 0, 2, 0)); // mul
    vecs.push_back(mk(0, 1, 5, 0, 1,  0, 0, 0,  0, 0,   1, 1, 1, 3, 0)); // addi
    vecs.push_back(mk(0, 1, 0, 1, 1,  1, 1, 1,  0, 0,   1, 1, 1, 4, 1)); // one drop
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 1,   1, 1, 1, 0, 0)); // clr keeps fifo
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 0, 0,  1, 0,   1, 4, 1, 1, 0)); // full + pop + push
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0,   1, 2, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0,   1, 5, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0)); // reset wins
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1,  0, 0, 0,  1, 0,   1, 3, 0, 1, 0)); // no bypass
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0,   0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 0, 0,  0, 1,   1, 1, 0, 0, 0)); // clr + push

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ev, vecs[i].op, vecs[i].al, vecs[i].ovf,
            vecs[i].mdd, vecs[i].mdiv, vecs[i].mexc, vecs[i].rdy, vecs[i].clr);
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(st_valid), 32'(vecs[i].e_v));
      chk($sformatf("vec%0d_data", i), st_data, 32'(vecs[i].e_d));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_s));
      chk($sformatf("vec%0d_count", i), 32'(exc_count), 32'(vecs[i].e_c));
      chk($sformatf("vec%0d_drop", i), 32'(drop_err), 32'(vecs[i].e_dr));
    end

    // Double pushes with continuous popping drive the counter into saturation.
    mstep("sat_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      mstep("sat", 0, 1, 0, 0, 1, 1, 0, 1, 1, 0);
    chk("sat_count_max", 32'(exc_count), 32'd15);
    chk("sat_drop_set", 32'(drop_err), 32'd1);

    mstep("rnd_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op, al;
      case ($urandom_range(0, 3))
        0: op = 5'd0;
        1: op = 5'd5;
        2: op = 5'd7;
        default: op = 5'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0: al = 5'd0;
        1: al = 5'd1;
        default: al = 5'($urandom);
      endcase
      mstep("rnd", $urandom_range(0, 99) == 0, 1'($urandom), op, al, 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
